// File: rtl/ws2812_driver.sv
// WS2812 pixel-chain driver: per-pixel colour buffer serialised as GRB, MSB first, then a latch gap.
// Define WS2812_AUTO_REFRESH_EN to repeat frames continuously instead of only after buffer writes.
module ws2812_driver #(
    parameter int NUM_LEDS  = 7,
    parameter int BIT_CYC   = 15,
    parameter int T0H_CYC   = 4,
    parameter int T1H_CYC   = 8,
    parameter int LATCH_CYC = 960
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [7:0]  led_num,
    input  logic [23:0] rgb_data,
    output logic        data,
    output logic        busy
);

    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CW = $clog2(BIT_CYC + 1);
    localparam int LW = $clog2(LATCH_CYC + 1);

    localparam logic [PW-1:0] PIX_LAST   = PW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] T0H_L      = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_L      = CW'(T1H_CYC);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);
    localparam logic [7:0]    NUM_LEDS_L = 8'(NUM_LEDS);
    localparam logic [4:0]    BIT_LAST   = 5'd23;

    typedef enum logic [1:0] {
        ST_LATCH,
        ST_IDLE,
        ST_SEND
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   latch_cnt_q, latch_cnt_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [4:0]      bit_q, bit_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic [23:0]     word_q, word_d;
    logic            dirty_q, dirty_d;
    logic            data_q, data_d;
    logic            busy_q, busy_d;

    logic [23:0]     pix_buf_q [NUM_LEDS];
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic [PW-1:0]   fetch_idx;
    logic [23:0]     fetch_rgb;
    logic [23:0]     fetch_word;

    assign wr_en  = write && (led_num < NUM_LEDS_L);
    assign wr_idx = led_num[PW-1:0];

    // NOTE: the colour buffer is plain storage with no reset; only control state is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pix_buf_q[wr_idx] <= rgb_data;
        end
    end

    // Outside SEND the next pixel to fetch is always pixel 0.
    assign fetch_idx  = (state_q == ST_SEND && pix_q != PIX_LAST) ? pix_q + PW'(1) : '0;
    assign fetch_rgb  = pix_buf_q[fetch_idx];
    assign fetch_word = {fetch_rgb[15:8], fetch_rgb[7:0], fetch_rgb[23:16]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        latch_cnt_d = latch_cnt_q;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        pix_d       = pix_q;
        word_d      = word_q;
        dirty_d     = dirty_q;

        case (state_q)
            ST_LATCH: begin
                if (latch_cnt_q == LATCH_LAST) begin
`ifdef WS2812_AUTO_REFRESH_EN
                    state_d = ST_SEND;
`else
                    state_d = dirty_q ? ST_SEND : ST_IDLE;
`endif
                end else begin
                    latch_cnt_d = latch_cnt_q + LW'(1);
                end
            end
            ST_IDLE: begin
                if (dirty_q) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (pix_q == PIX_LAST) begin
                            pix_d       = '0;
                            latch_cnt_d = '0;
                            state_d     = ST_LATCH;
                        end else begin
                            pix_d  = fetch_idx;
                            word_d = fetch_word;
                        end
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        word_d = {word_q[22:0], 1'b0};
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = ST_LATCH;
        endcase

        // Frame start: pixel 0 is captured on the same edge its first bit begins.
        if (state_q != ST_SEND && state_d == ST_SEND) begin
            cyc_d   = '0;
            bit_d   = '0;
            pix_d   = '0;
            word_d  = fetch_word;
            dirty_d = 1'b0;
        end

        if (wr_en) begin
            dirty_d = 1'b1;
        end

        // Outputs are computed from next-state so the registered pin lines up with the bit slot.
        busy_d = (state_d == ST_SEND);
        data_d = busy_d && (cyc_d < (word_d[23] ? T1H_L : T0H_L));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LATCH;
            latch_cnt_q <= '0;
            cyc_q       <= '0;
            bit_q       <= '0;
            pix_q       <= '0;
            word_q      <= '0;
            dirty_q     <= 1'b1;
            data_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            latch_cnt_q <= latch_cnt_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            pix_q       <= pix_d;
            word_q      <= word_d;
            dirty_q     <= dirty_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
        end
    end

    assign data = data_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Self-checking bench for ws2812_driver (two-pixel chain, default timing, refresh-on-write build).
module tb_ws2812_driver;

    localparam int NUM_LEDS = 2;
    localparam int BIT_CYC  = 15;
    localparam int T0H      = 4;
    localparam int T1H      = 8;
    localparam int LATCH    = 960;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        write    = 1'b0;
    logic [7:0]  led_num  = 8'd0;
    logic [23:0] rgb_data = 24'd0;
    logic        data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    ws2812_driver #(
        .NUM_LEDS (NUM_LEDS),
        .BIT_CYC  (BIT_CYC),
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .LATCH_CYC(LATCH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .write   (write),
        .led_num (led_num),
        .rgb_data(rgb_data),
        .data    (data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  led;
        logic [23:0] rgb;
        bit          valid;
        logic [23:0] w0;
        logic [23:0] w1;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Called on a falling edge; returns one falling edge later with write deasserted.
    task automatic do_write(input logic [7:0] led, input logic [23:0] rgb);
        write    = 1'b1;
        led_num  = led;
        rgb_data = rgb;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic wait_busy(input int max_cyc, output int n, output bit hi);
        n  = 0;
        hi = 1'b0;
        while (busy !== 1'b1 && n < max_cyc) begin
            if (data !== 1'b0) hi = 1'b1;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic expect_gap(input string name, input int max_cyc, input int exp_n);
        int n;
        bit hi;
        wait_busy(max_cyc, n, hi);
        check({name, "_len"}, 32'(n), 32'(exp_n));
        check({name, "_low"}, 32'(hi), 32'd0);
    endtask

    // Entered on the falling edge of the first busy cycle; leaves on the edge just after the frame.
    task automatic check_frame(input string name, input logic [23:0] w0, input logic [23:0] w1);
        logic [23:0] w;
        logic [14:0] obs;
        logic [14:0] exp;
        bit          busy_ok;
        busy_ok = 1'b1;
        for (int p = 0; p < NUM_LEDS; p++) begin
            w = (p == 0) ? w0 : w1;
            for (int k = 23; k >= 0; k--) begin
                for (int c = 0; c < BIT_CYC; c++) begin
                    obs[c] = data;
                    exp[c] = (c < (w[k] ? T1H : T0H));
                    if (busy !== 1'b1) busy_ok = 1'b0;
                    @(negedge clk);
                end
                check($sformatf("%s_p%0d_b%0d", name, p, k), 32'(obs), 32'(exp));
            end
        end
        check({name, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'd0,   24'h0000FF, 1'b1, 24'h00FF00, 24'h000000};
        vecs[1] = '{8'd1,   24'h00FF00, 1'b1, 24'h00FF00, 24'hFF0000};
        vecs[2] = '{8'd2,   24'hFFFFFF, 1'b0, 24'h000000, 24'h000000};
        vecs[3] = '{8'd1,   24'hA53C81, 1'b1, 24'h00FF00, 24'h3C81A5};
        vecs[4] = '{8'd7,   24'h0F0F0F, 1'b0, 24'h000000, 24'h000000};
        vecs[5] = '{8'd0,   24'h123456, 1'b1, 24'h345612, 24'h3C81A5};
        vecs[6] = '{8'd255, 24'hFFFFFF, 1'b0, 24'h000000, 24'h000000};
        vecs[7] = '{8'd1,   24'hFF0000, 1'b1, 24'h345612, 24'h0000FF};

        // Reset: clear the buffer through the write port while held in reset.
        @(negedge clk);
        do_write(8'd0, 24'd0);
        do_write(8'd1, 24'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        expect_gap("boot_latch", 2000, LATCH);
        check_frame("boot", 24'h000000, 24'h000000);
        expect_gap("boot_idle", 3000, 3000);

        for (int i = 0; i < 8; i++) begin
            do_write(vecs[i].led, vecs[i].rgb);
            if (vecs[i].valid) begin
                expect_gap($sformatf("v%0d_lat", i), 100, 1);
                check_frame($sformatf("v%0d", i), vecs[i].w0, vecs[i].w1);
            end
            expect_gap($sformatf("v%0d_quiet", i), 1200, 1200);
        end

        // Writes during pixel 0: pixel 1 updates now, pixel 0 only in the extra frame.
        do_write(8'd0, 24'h0000FF);
        expect_gap("mid_lat", 100, 1);
        fork
            check_frame("mid_f1", 24'h00FF00, 24'hFF0000);
            begin
                repeat (30) @(negedge clk);
                do_write(8'd1, 24'h00FF00);
                do_write(8'd0, 24'hFFFFFF);
            end
        join
        expect_gap("mid_gap", 1500, LATCH);
        check_frame("mid_f2", 24'hFFFFFF, 24'hFF0000);
        expect_gap("mid_quiet", 1500, 1500);

        // Pixel 1 capture edge: the write one cycle earlier lands, the write on the capture edge does not.
        do_write(8'd0, 24'h000000);
        expect_gap("cap_lat", 100, 1);
        fork
            check_frame("cap_f1", 24'h000000, 24'h00FF00);
            begin
                repeat (24 * BIT_CYC - 2) @(negedge clk);
                do_write(8'd1, 24'h0000FF);
                do_write(8'd1, 24'hFF0000);
            end
        join
        expect_gap("cap_gap", 1500, LATCH);
        check_frame("cap_f2", 24'h000000, 24'h0000FF);
        expect_gap("cap_quiet", 1500, 1500);

        // Reset 100 cycles into a frame.
        do_write(8'd0, 24'hAAAAAA);
        expect_gap("arst_lat", 100, 1);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_data_now", 32'(data), 32'd0);
        check("arst_busy_now", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("arst_busy_held", 32'(busy), 32'd0);
        reset = 1'b0;
        expect_gap("arst_gap", 2000, LATCH);
        check_frame("arst_f", 24'hAAAAAA, 24'h0000FF);
        expect_gap("arst_quiet", 1500, 1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
